// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Purpose:
//    Round-robin arbiter that owns a 3-to-8 decoder. One of eight requesters
//    is granted at a time. The granted index is presented on {w0,w1,w2}
//    (w0 = MSB), and en enables the decoder while the grant is held. Every
//    grant is followed by a RELEASE cycle and an IDLE cycle. This keeps the
//    decoder select lines from ever changing while en is high.
//
// Ports:
//    clk      in   1  rising-edge clock
//    rst_n    in   1  asynchronous active-low reset
//    req      in   8  request vector, bit i = requester i
//    done     in   1  owner releases the decoder (looked at only in GRANT)
//    w0       out  1  MSB of granted index
//    w1       out  1  middle bit of granted index
//    w2       out  1  LSB of granted index
//    en       out  1  decoder enable, high only in GRANT
//    gnt      out  8  one-hot grant, gnt[i] = en & ({w0,w1,w2} == i)
//    busy     out  1  high in GRANT or RELEASE
//    timeout  out  1  one-cycle pulse on a forced release
//
// Parameters:
//    MAX_HOLD  longest grant in cycles (2..255), used only with the timeout
//
// Configuration macro:
//    ARB_TIMEOUT_EN  when defined, an 8-bit hold timer bounds every grant to
//                    MAX_HOLD cycles. When it is not defined, grants are
//                    unbounded and timeout is tied low.
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
   parameter int MAX_HOLD = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic       w0,
   output logic       w1,
   output logic       w2,
   output logic       en,
   output logic [7:0] gnt,
   output logic       busy,
   output logic       timeout
);

   // Stop elaboration on an out-of-range hold limit.
   if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
      $error("decoder_rr_arbiter: MAX_HOLD must be within 2..255");
   end

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_s;
   logic [2:0] idx_r;      // index driven onto {w0,w1,w2}
   logic [2:0] idx_s;
   logic [2:0] last_r;     // most recently granted index
   logic [2:0] last_s;
   logic       en_r;
   logic [7:0] gnt_r;
   logic [7:0] gnt_s;
   logic       busy_r;

   // Round-robin search. Returns the first set bit of r, starting one place
   // above from_last and wrapping 7->0. The caller makes sure r is non-zero.
   // The search ends at offset 8 (from_last itself), so a lone requester that
   // was just served can win again.
   function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                          input logic [2:0] from_last);
      logic [2:0] cand;
      logic [2:0] win;
      logic       hit;
      win = 3'd0;
      hit = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cand = from_last + k[2:0];
         win  = (!hit && r[cand]) ? cand : win;
         hit  = hit | r[cand];
      end
      return win;
   endfunction

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] timer_r;
   logic [7:0] timer_s;
   logic       tmo_fire_s;
   logic       timeout_r;

   // Hold timer. It is zero in the first GRANT cycle and counts up while the
   // FSM stays in GRANT. It is also zero in every other state, so it starts
   // from zero on each new grant.
   always_comb begin
      timer_s = (state_r == ST_GRANT) ? (timer_r + 8'd1) : 8'd0;
   end
`endif

   // Next-state logic, winner latch, and precomputed registered outputs.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      last_s  = last_r;
`ifdef ARB_TIMEOUT_EN
      tmo_fire_s = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (req != 8'h00) begin
               state_s = ST_GRANT;
               idx_s   = rr_pick(req, last_r);
               last_s  = idx_s;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            // A normal release wins over a timeout in the same cycle. New
            // requests from other requesters do not extend the grant.
            if (done || !req[idx_r]) begin
               state_s = ST_RELEASE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (timer_r == HOLD_LAST) begin
               state_s    = ST_RELEASE;
               tmo_fire_s = 1'b1;
            end
`endif
            else begin
               state_s = ST_GRANT;
            end
         end
         ST_RELEASE: begin
            // Exactly one dead cycle. req and done are ignored here.
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      gnt_s = (state_s == ST_GRANT) ? (8'h01 << idx_s) : 8'h00;
   end

   // State and output registers. Reset clears every output immediately,
   // including in the middle of a grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         idx_r   <= 3'd0;
         last_r  <= 3'd7;
         en_r    <= 1'b0;
         gnt_r   <= 8'h00;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         last_r  <= last_s;
         en_r    <= (state_s == ST_GRANT);
         gnt_r   <= gnt_s;
         busy_r  <= (state_s != ST_IDLE);
      end
   end

`ifdef ARB_TIMEOUT_EN
   // Hold timer and timeout pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_r   <= 8'd0;
         timeout_r <= 1'b0;
      end else begin
         timer_r   <= timer_s;
         timeout_r <= tmo_fire_s;
      end
   end

   assign timeout = timeout_r;
`else
   assign timeout = 1'b0;
`endif

   assign w0   = idx_r[2];
   assign w1   = idx_r[1];
   assign w2   = idx_r[0];
   assign en   = en_r;
   assign gnt  = gnt_r;
   assign busy = busy_r;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//
// Self-checking bench for decoder_rr_arbiter. A transaction-level reference
// model (owner index, phase, grant length) runs on each rising edge with the
// inputs the DUT sampled. Outputs are compared 1 ns after the edge.
// -----------------------------------------------------------------------------
module tb_decoder_rr_arbiter;

   localparam int HOLD = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] req   = 8'h00;
   logic       done  = 1'b0;
   logic       w0, w1, w2, en, busy, timeout;
   logic [7:0] gnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: phase 0 = idle, 1 = owned, 2 = release gap.
   int         m_phase;
   int         m_last;
   logic [2:0] m_idx;
   int         m_held;
   logic       m_tmo;

   decoder_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .done    (done),
      .w0      (w0),
      .w1      (w1),
      .w2      (w2),
      .en      (en),
      .gnt     (gnt),
      .busy    (busy),
      .timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_phase = 0;
      m_last  = 7;
      m_idx   = 3'd0;
      m_held  = 0;
      m_tmo   = 1'b0;
   endtask

   task automatic model_edge(input logic [7:0] r, input logic d);
      bit found;
      int pick;
      m_tmo = 1'b0;
      if (m_phase == 0) begin
         found = 0;
         pick  = 0;
         for (int k = 1; k <= 8; k++) begin
            if (!found && r[(m_last + k) % 8]) begin
               found = 1;
               pick  = (m_last + k) % 8;
            end
         end
         if (found) begin
            m_phase = 1;
            m_idx   = 3'(pick);
            m_last  = pick;
            m_held  = 1;
         end
      end else if (m_phase == 1) begin
         if (d || !r[m_idx]) m_phase = 2;
`ifdef ARB_TIMEOUT_EN
         else if (m_held >= HOLD) begin
            m_phase = 2;
            m_tmo   = 1'b1;
         end
`endif
         else m_held++;
      end else begin
         m_phase = 0;
      end
   endtask

   function automatic logic [13:0] exp_vec();
      logic [7:0] g;
      g = (m_phase == 1) ? (8'h01 << m_idx) : 8'h00;
      return {(m_phase != 0), m_tmo, (m_phase == 1), m_idx, g};
   endfunction

   function automatic logic [13:0] obs_vec();
      return {busy, timeout, en, w0, w1, w2, gnt};
   endfunction

   task automatic step();
      @(posedge clk);
      if (rst_n) model_edge(req, done);
      else model_reset();
      #1;
   endtask

   task automatic do_reset();
      req   = 8'h00;
      done  = 1'b0;
      rst_n = 1'b0;
      model_reset();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      model_reset();
      #2;
      n_checks++;
      if (obs_vec() !== 14'h0000) begin
         n_errors++;
         $display("FAIL reset_state: got %h want %h", obs_vec(), 14'h0000);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (obs_vec() !== exp_vec() || en !== 1'b0 || gnt !== 8'h00 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_no_req cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_pair();
      logic [7:0] rq [7];
      logic       dn [7];
      rq = '{8'h24, 8'h24, 8'h24, 8'h24, 8'h00, 8'h00, 8'h00};
      dn = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         req  = rq[i];
         done = dn[i];
         step();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL pair_seq cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
         if (i == 0 || i == 3) begin
            n_checks++;
            if (gnt !== ((i == 0) ? 8'h04 : 8'h20) ||
                {w0, w1, w2} !== ((i == 0) ? 3'b010 : 3'b101)) begin
               n_errors++;
               $display("FAIL pair_grant cyc %0d: got gnt=%h w=%b want gnt=%h w=%b", i, gnt,
                        {w0, w1, w2}, (i == 0) ? 8'h04 : 8'h20, (i == 0) ? 3'b010 : 3'b101);
            end
         end
      end
   endtask

   task automatic test_fairness();
      int order[$];
      int gap;
      bit prev_en;
      do_reset();
      req     = 8'hFF;
      done    = 1'b1;
      gap     = 0;
      prev_en = 1'b0;
      for (int i = 0; i < 60 && order.size() < 9; i++) begin
         step();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL fair_seq cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
         if (en && !prev_en) begin
            if (order.size() > 0) begin
               n_checks++;
               if (gap != 2) begin
                  n_errors++;
                  $display("FAIL fair_gap: got %0d dead cycles want 2", gap);
               end
            end
            order.push_back(int'({w0, w1, w2}));
            gap = 0;
         end else if (!en) begin
            gap++;
         end
         prev_en = en;
      end
      n_checks++;
      if (order.size() != 9) begin
         n_errors++;
         $display("FAIL fair_count: got %0d grants want 9", order.size());
      end
      for (int i = 0; i < order.size(); i++) begin
         n_checks++;
         if (order[i] != i % 8) begin
            n_errors++;
            $display("FAIL fair_order[%0d]: got %0d want %0d", i, order[i], i % 8);
         end
      end
      req  = 8'h00;
      done = 1'b0;
   endtask

   task automatic test_owner_drop();
      do_reset();
      req = 8'h40;
      step();
      n_checks++;
      if (obs_vec() !== exp_vec() || gnt !== 8'h40) begin
         n_errors++;
         $display("FAIL drop_grant: got %h want %h", obs_vec(), exp_vec());
      end
      req = 8'h0F;   // owner drops; others requesting must not hold the grant
      step();
      n_checks++;
      if (obs_vec() !== exp_vec() || en !== 1'b0 || busy !== 1'b1 || timeout !== 1'b0) begin
         n_errors++;
         $display("FAIL drop_release: got %h want %h", obs_vec(), exp_vec());
      end
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_errors++;
         $display("FAIL drop_idle: got %h want %h", obs_vec(), exp_vec());
      end
      req = 8'h00;
      step();
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 8'h08;
      step();
      n_checks++;
      if (obs_vec() !== exp_vec() || gnt !== 8'h08) begin
         n_errors++;
         $display("FAIL ares_grant: got %h want %h", obs_vec(), exp_vec());
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (en !== 1'b0 || gnt !== 8'h00 || obs_vec() !== 14'h0000) begin
         n_errors++;
         $display("FAIL ares_drop: got %h want %h", obs_vec(), 14'h0000);
      end
      step();
      rst_n = 1'b1;
      step();
      n_checks++;
      if (obs_vec() !== exp_vec() || gnt !== 8'h08 || {w0, w1, w2} !== 3'b011) begin
         n_errors++;
         $display("FAIL ares_regrant: got %h want %h", obs_vec(), exp_vec());
      end
      req = 8'h00;
      step();
      step();
   endtask

   task automatic test_hold();
      do_reset();
      req  = 8'h01;
      done = 1'b0;
      for (int i = 0; i < 14; i++) begin
         step();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL hold_seq cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      req = 8'h00;
      step();
      step();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0) req = 8'($urandom_range(0, 255));
         else if ($urandom_range(0, 5) == 0) req = 8'h00;
         done = ($urandom_range(0, 4) == 0);
         step();
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL random cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_pair();
      test_fairness();
      test_owner_drop();
      test_async_reset();
      test_hold();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
